bp_checkpoint_ctrl: RTL and testbench
=====================================

# bp_checkpoint_ctrl

Sequencer for the dual-bank BTB checkpoint scheme. Owns the `checkpoint_mode` select that steers branch-predictor updates and predictions between bank A (normal) and bank B (checkpoint). Enter and exit requests are run as handshaked transitions. Before each mode flip the block stalls and drains updates through the registered update path. On entry it flushes bank B, and it bounds checkpoint residency with a timeout. It sits in the frontend between the checkpoint requester and the BTB bank mux.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 1: consecutive update-free cycles required before a mode flip. This covers the one-cycle registered update path in the mux.
- `FLUSH_CYCLES`, default 2: cycles `flush_b_o` is held high on entry.
- `MAX_CKPT_CYCLES`, default 1024: maximum cycles in checkpoint mode before a forced exit. 0 disables the timeout.
- `CNT_W`, default 16: width of the residency counter. Requires `MAX_CKPT_CYCLES < 2**CNT_W`.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset. One clock domain; reset is synchronous and active-high.
- `enter_req_i`, input, 1: level request to enter checkpoint mode.
- `exit_req_i`, input, 1: level request to leave checkpoint mode.
- `debug_mode_i`, input, 1: debug mode. Blocks entry and forces exit.
- `flush_i`, input, 1: global frontend flush.
- `btb_update_valid_i`, input, 1: valid bit of the incoming BTB update.
- `checkpoint_mode_o`, output, 1: bank select. 0 selects bank A, 1 selects bank B.
- `flush_b_o`, output, 1: flush strobe for bank B.
- `update_stall_o`, output, 1: upstream must not issue BTB updates while this is high.
- `enter_ack_o`, output, 1: one-cycle pulse when checkpoint mode is active.
- `exit_ack_o`, output, 1: one-cycle pulse when normal mode is restored.
- `enter_abort_o`, output, 1: one-cycle pulse when an entry is cancelled.
- `timeout_o`, output, 1: one-cycle pulse on a forced exit due to timeout.
- `busy_o`, output, 1: high in any transitional state.
- `ckpt_cycles_o`, output, `CNT_W`: cycles spent in the current or most recent checkpoint.

## Operation
- States: IDLE, ENTER_DRAIN, ENTER_FLUSH, CKPT, EXIT_DRAIN.
- Reset: state is IDLE, the drain and flush counters are 0, and every output is 0, including `ckpt_cycles_o`.
- IDLE:
  - `checkpoint_mode_o` = 0 and `update_stall_o` = 0.
  - `enter_req_i && !debug_mode_i` moves to ENTER_DRAIN, loads the drain counter with `DRAIN_CYCLES`, and clears `ckpt_cycles_o`.
  - `exit_req_i` is ignored in IDLE.
- ENTER_DRAIN:
  - `update_stall_o` = 1 and `busy_o` = 1.
  - The drain counter decrements on each cycle with `btb_update_valid_i` = 0. It reloads to `DRAIN_CYCLES` on any cycle with `btb_update_valid_i` = 1.
  - When the counter reaches 0, move to ENTER_FLUSH and load the flush counter with `FLUSH_CYCLES`.
  - `flush_i` or `debug_mode_i` takes priority over the drain: return to IDLE and pulse `enter_abort_o`.
- ENTER_FLUSH:
  - `flush_b_o` = 1 and `update_stall_o` = 1.
  - The flush counter decrements every cycle. At 0, move to CKPT.
  - This state is not abortable.
- CKPT:
  - `checkpoint_mode_o` = 1, `update_stall_o` = 0, `busy_o` = 0.
  - `enter_ack_o` pulses on the first CKPT cycle.
  - `ckpt_cycles_o` increments each cycle and saturates at all-ones.
  - Exit to EXIT_DRAIN (drain counter reloaded) on any of:
    - `exit_req_i`;
    - `debug_mode_i`;
    - `MAX_CKPT_CYCLES != 0` and `ckpt_cycles_o == MAX_CKPT_CYCLES-1`. This case also pulses `timeout_o` on the same cycle.
  - `enter_req_i` is ignored in CKPT.
- EXIT_DRAIN:
  - `checkpoint_mode_o` stays 1, `update_stall_o` = 1, `busy_o` = 1.
  - Drain rule is the same as ENTER_DRAIN.
  - At 0, move to IDLE and pulse `exit_ack_o`.
  - `flush_i` is ignored, so an exit always completes.
- Simultaneous events:
  - `enter_req_i` and `exit_req_i` together in IDLE: entry proceeds.
  - `exit_req_i` and timeout together in CKPT: a single exit, with `timeout_o` pulsed.
- Reset asserted in any state: the next cycle is IDLE with outputs at their reset values. No acks are issued.

## Timing
- All outputs are registered and driven from state. There is no combinational input-to-output path.
- Entry latency, from `enter_req_i` sampled high in IDLE to `checkpoint_mode_o` = 1, with no updates pending: 1 + `DRAIN_CYCLES` + `FLUSH_CYCLES` cycles. With defaults this is 4.
- Exit latency, from `exit_req_i` sampled high in CKPT to `checkpoint_mode_o` = 0: 1 + `DRAIN_CYCLES` cycles.
- Mode flips always coincide with `update_stall_o` high. No update is in flight across a flip.
- `enter_ack_o` and `exit_ack_o` assert in the same cycle that `checkpoint_mode_o` takes its new value.

## Test plan
- Reset with `rst_i` = 1 for 2 cycles, then 0 -> all outputs 0, state IDLE, `checkpoint_mode_o` = 0.
- Pulse `enter_req_i` for 1 cycle with no updates, defaults -> `update_stall_o` high cycles 1–3, `flush_b_o` high cycles 2–3, `checkpoint_mode_o` = 1 and `enter_ack_o` = 1 at cycle 4.
- Enter with `btb_update_valid_i` = 1 for 3 cycles during ENTER_DRAIN -> drain restarts each time. Mode flip is delayed by 3 cycles versus the previous case.
- `flush_i` = 1 in ENTER_DRAIN -> `enter_abort_o` pulse, return to IDLE, `flush_b_o` never asserted, mode stays 0.
- `MAX_CKPT_CYCLES` = 8, enter and hold -> `timeout_o` at the cycle `ckpt_cycles_o` = 7, mode returns to 0 two cycles later with `exit_ack_o`.
- `debug_mode_i` = 1 while in CKPT -> exit sequence runs, `exit_ack_o` pulses. A subsequent `enter_req_i` is ignored while `debug_mode_i` remains 1.

Source files
------------

// File: rtl/bp_checkpoint_ctrl.sv
// Checkpoint-mode sequencer for the dual-bank BTB: drains updates before each bank flip,
// flushes bank B on entry and bounds the time spent in checkpoint mode.
module bp_checkpoint_ctrl #(
    parameter int DRAIN_CYCLES    = 1,
    parameter int FLUSH_CYCLES    = 2,
    parameter int MAX_CKPT_CYCLES = 1024,
    parameter int CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enter_req_i,
    input  logic             exit_req_i,
    input  logic             debug_mode_i,
    input  logic             flush_i,
    input  logic             btb_update_valid_i,
    output logic             checkpoint_mode_o,
    output logic             flush_b_o,
    output logic             update_stall_o,
    output logic             enter_ack_o,
    output logic             exit_ack_o,
    output logic             enter_abort_o,
    output logic             timeout_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] ckpt_cycles_o
);

    localparam int DW = 16;
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0]    FLUSH_LOAD = DW'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CKPT_CYCLES - 1);
    localparam bit               TIMEOUT_EN = (MAX_CKPT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE,
        ENTER_DRAIN,
        ENTER_FLUSH,
        CKPT,
        EXIT_DRAIN
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DW-1:0]     drain_cnt;
    logic [DW-1:0]     flush_cnt;
    logic [CNT_W-1:0]  ckpt_cnt;
    logic              exit_ack_q;
    logic              abort_q;
    logic              drain_done;
    logic              flush_done;
    logic              timeout_hit;

    // A drain finishes on the update-free cycle that would take the counter to zero.
    assign drain_done  = !btb_update_valid_i && (drain_cnt <= DW'(1));
    assign flush_done  = (flush_cnt <= DW'(1));
    assign timeout_hit = TIMEOUT_EN && (state == CKPT) && (ckpt_cnt == TIMEOUT_AT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            exit_ack_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state      <= next_state;
            exit_ack_q <= (state == EXIT_DRAIN) && (next_state == IDLE);
            abort_q    <= (state == ENTER_DRAIN) && (next_state == IDLE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (enter_req_i && !debug_mode_i) next_state = ENTER_DRAIN;
            ENTER_DRAIN: begin
                if (flush_i || debug_mode_i) next_state = IDLE;
                else if (drain_done)         next_state = ENTER_FLUSH;
            end
            ENTER_FLUSH: if (flush_done) next_state = CKPT;
            CKPT:        if (exit_req_i || debug_mode_i || timeout_hit) next_state = EXIT_DRAIN;
            EXIT_DRAIN:  if (drain_done) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_cnt <= '0;
            flush_cnt <= '0;
            ckpt_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (next_state == ENTER_DRAIN) begin
                        drain_cnt <= DRAIN_LOAD;
                        ckpt_cnt  <= '0;
                    end
                end
                ENTER_DRAIN, EXIT_DRAIN: begin
                    if (btb_update_valid_i)  drain_cnt <= DRAIN_LOAD;
                    else if (drain_cnt != 0) drain_cnt <= drain_cnt - DW'(1);
                    if (next_state == ENTER_FLUSH) flush_cnt <= FLUSH_LOAD;
                end
                ENTER_FLUSH: begin
                    if (flush_cnt != 0) flush_cnt <= flush_cnt - DW'(1);
                end
                CKPT: begin
                    if (ckpt_cnt != '1) ckpt_cnt <= ckpt_cnt + CNT_W'(1);
                    if (next_state == EXIT_DRAIN) drain_cnt <= DRAIN_LOAD;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only, so nothing is combinational from the inputs.
    always_comb begin
        checkpoint_mode_o = 1'b0;
        flush_b_o         = 1'b0;
        update_stall_o    = 1'b0;
        busy_o            = 1'b0;
        enter_ack_o       = 1'b0;
        case (state)
            ENTER_DRAIN: begin
                update_stall_o = 1'b1;
                busy_o         = 1'b1;
            end
            ENTER_FLUSH: begin
                flush_b_o      = 1'b1;
                update_stall_o = 1'b1;
                busy_o         = 1'b1;
            end
            CKPT: begin
                checkpoint_mode_o = 1'b1;
                enter_ack_o       = (ckpt_cnt == '0);
            end
            EXIT_DRAIN: begin
                checkpoint_mode_o = 1'b1;
                update_stall_o    = 1'b1;
                busy_o            = 1'b1;
            end
            default: ;
        endcase
    end

    assign exit_ack_o    = exit_ack_q;
    assign enter_abort_o = abort_q;
    assign timeout_o     = timeout_hit;
    assign ckpt_cycles_o = ckpt_cnt;

endmodule

// File: tb/tb_bp_checkpoint_ctrl.sv
// Scoreboard bench for bp_checkpoint_ctrl: directed stimulus queues cycle-stamped
// expected output snapshots, a negedge monitor pops and compares them.
module tb_bp_checkpoint_ctrl;

    localparam logic [7:0] MODE = 8'h80, FLB = 8'h40, STL = 8'h20, EACK = 8'h10;
    localparam logic [7:0] XACK = 8'h08, ABT = 8'h04, TMO = 8'h02, BSY = 8'h01;

    typedef struct {
        int          cyc;
        logic [7:0]  flags;
        logic [15:0] ckpt;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enter_req, exit_req, debug_mode, flush, update_valid;
    logic        checkpoint_mode, flush_b, update_stall, enter_ack, exit_ack;
    logic        enter_abort, timeout, busy;
    logic [15:0] ckpt_cycles;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    bp_checkpoint_ctrl #(
        .DRAIN_CYCLES(1),
        .FLUSH_CYCLES(2),
        .MAX_CKPT_CYCLES(8),
        .CNT_W(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enter_req_i(enter_req),
        .exit_req_i(exit_req),
        .debug_mode_i(debug_mode),
        .flush_i(flush),
        .btb_update_valid_i(update_valid),
        .checkpoint_mode_o(checkpoint_mode),
        .flush_b_o(flush_b),
        .update_stall_o(update_stall),
        .enter_ack_o(enter_ack),
        .exit_ack_o(exit_ack),
        .enter_abort_o(enter_abort),
        .timeout_o(timeout),
        .busy_o(busy),
        .ckpt_cycles_o(ckpt_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expectAt(input int c, input logic [7:0] f, input logic [15:0] k, input string n);
        exp_t e;
        e.cyc = c; e.flags = f; e.ckpt = k; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic en, input logic ex, input logic dbg,
                                 input logic fl, input logic upd, input int n);
        enter_req = en; exit_req = ex; debug_mode = dbg; flush = fl; update_valid = upd;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [7:0] act;
        act = {checkpoint_mode, flush_b, update_stall, enter_ack, exit_ack, enter_abort, timeout, busy};
        vectors++;
        if (act !== e.flags || ckpt_cycles !== e.ckpt) begin
            miscompares++;
            $display("[TB] FAIL %s @cyc %0d: got flags=%b ckpt=%0d, expected flags=%b ckpt=%0d",
                     e.name, cyc, act, ckpt_cycles, e.flags, e.ckpt);
        end
    endtask

    // Monitor: compare whenever a snapshot is due, and flag any strobe nobody expected.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: snapshot for cyc %0d never compared, now cyc %0d", e.name, e.cyc, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checkOutput(e);
        end else if (rst === 1'b0 && (enter_ack === 1'b1 || exit_ack === 1'b1 || enter_abort === 1'b1 ||
                                      timeout === 1'b1 || flush_b === 1'b1)) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_strobe @cyc %0d: got ack=%b xack=%b abort=%b tmo=%b flush_b=%b, expected all 0",
                     cyc, enter_ack, exit_ack, enter_abort, timeout, flush_b);
        end
    end

    initial begin
        int b;
        rst = 1'b1;
        expectAt(2, 8'h00, 16'd0, "reset");
        applyStimulus(0, 0, 0, 0, 0, 2);
        rst = 1'b0;
        expectAt(3, 8'h00, 16'd0, "idle_after_reset");
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Entry with enter and exit together, then a requested exit.
        b = cyc;
        expectAt(b + 1, STL | BSY,        16'd0, "entry_drain");
        expectAt(b + 2, FLB | STL | BSY,  16'd0, "entry_flush0");
        expectAt(b + 3, FLB | STL | BSY,  16'd0, "entry_flush1");
        expectAt(b + 4, MODE | EACK,      16'd0, "entry_ack");
        expectAt(b + 5, MODE | STL | BSY, 16'd1, "exit_drain");
        expectAt(b + 6, XACK,             16'd1, "exit_ack");
        expectAt(b + 7, 8'h00,            16'd1, "idle_after_exit");
        applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 3);
        applyStimulus(0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 2);

        // Entry with three update cycles restarting the drain, then a debug-forced exit.
        b = cyc;
        for (int i = 1; i <= 4; i++) expectAt(b + i, STL | BSY, 16'd0, "upd_drain");
        expectAt(b + 5, FLB | STL | BSY,  16'd0, "upd_flush0");
        expectAt(b + 6, FLB | STL | BSY,  16'd0, "upd_flush1");
        expectAt(b + 7, MODE | EACK,      16'd0, "upd_entry_ack");
        expectAt(b + 8, MODE | STL | BSY, 16'd1, "dbg_exit_drain");
        expectAt(b + 9, XACK,             16'd1, "dbg_exit_ack");
        for (int i = 10; i <= 13; i++) expectAt(b + i, 8'h00, 16'd1, "dbg_blocks_entry");
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 3);
        applyStimulus(0, 0, 0, 0, 0, 3);
        applyStimulus(0, 0, 1, 0, 0, 2);
        applyStimulus(1, 0, 1, 0, 0, 3);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Frontend flush during the entry drain aborts it.
        b = cyc;
        expectAt(b + 1, STL | BSY, 16'd0, "abort_drain");
        expectAt(b + 2, ABT,       16'd0, "abort_pulse");
        expectAt(b + 3, 8'h00,     16'd0, "idle_after_abort");
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Held entry request times out; exit request lands on the timeout cycle.
        b = cyc;
        expectAt(b + 1, STL | BSY,       16'd0, "to_drain");
        expectAt(b + 2, FLB | STL | BSY, 16'd0, "to_flush0");
        expectAt(b + 3, FLB | STL | BSY, 16'd0, "to_flush1");
        expectAt(b + 4, MODE | EACK,     16'd0, "to_entry_ack");
        for (int i = 1; i <= 6; i++) expectAt(b + 4 + i, MODE, 16'(i), "to_resident");
        expectAt(b + 11, MODE | TMO,       16'd7, "to_timeout");
        expectAt(b + 12, MODE | STL | BSY, 16'd8, "to_exit_drain");
        expectAt(b + 13, XACK,             16'd8, "to_exit_ack");
        expectAt(b + 14, 8'h00,            16'd8, "to_idle0");
        expectAt(b + 15, 8'h00,            16'd8, "to_idle1");
        applyStimulus(1, 0, 0, 0, 0, 11);
        applyStimulus(0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 3);

        applyStimulus(0, 0, 0, 0, 0, 2);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: snapshot for cyc %0d left unchecked at end", e.name, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
